// File: rtl/fifo_wrr_arbiter.sv
// Burst-limited round-robin merge of several FWFT source FIFOs into one output FIFO.
// Each grant drains up to BURST_MAX words, and one bubble cycle follows every grant switch.
module fifo_wrr_arbiter #(
    parameter int N_SRC     = 3,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 16,
    parameter int CNT_W     = 16
) (
    input  logic                      BUS_CLK,
    input  logic                      BUS_RST,
    input  logic [N_SRC-1:0]          SRC_EN,
    input  logic [N_SRC-1:0]          SRC_EMPTY,
    input  logic [N_SRC*DATA_W-1:0]   SRC_DATA,
    output logic [N_SRC-1:0]          SRC_READ,
    input  logic                      OUT_FULL,
    output logic                      OUT_WRITE,
    output logic [DATA_W-1:0]         OUT_DATA,
    output logic [$clog2(N_SRC)-1:0]  GRANT_ID,
    output logic                      BUSY,
    input  logic                      CNT_CLR,
    output logic [N_SRC*CNT_W-1:0]    WORD_CNT
);

    localparam int GW = $clog2(N_SRC);
    localparam logic [7:0] BMAX = 8'(BURST_MAX);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t            state;
    logic [GW-1:0]     ptr;
    logic [GW-1:0]     pick;
    logic              found;
    logic [7:0]        burst;
    logic [N_SRC-1:0]  req;
    logic              pop;
    logic [DATA_W-1:0] gdata;
    logic [CNT_W-1:0]  cnt [N_SRC];

    assign req   = SRC_EN & ~SRC_EMPTY;
    assign gdata = SRC_DATA[GRANT_ID*DATA_W +: DATA_W];

    // Disabled or empty granted source never pops; reset masks pops too.
    assign pop = (state == SERVE) & SRC_EN[GRANT_ID] & ~SRC_EMPTY[GRANT_ID]
               & ~OUT_FULL & ~BUS_RST;

    always_comb begin
        SRC_READ           = '0;
        SRC_READ[GRANT_ID] = pop;
    end

    // First requester after the pointer, wrapping modulo N_SRC.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (!found && req[(int'(ptr) + k) % N_SRC]) begin
                pick  = GW'((int'(ptr) + k) % N_SRC);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state     <= IDLE;
            ptr       <= GW'(N_SRC - 1);
            burst     <= '0;
            GRANT_ID  <= '0;
            BUSY      <= 1'b0;
            OUT_WRITE <= 1'b0;
            OUT_DATA  <= '0;
        end else begin
            OUT_WRITE <= pop;
            if (pop) OUT_DATA <= gdata;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        GRANT_ID <= pick;
                        ptr      <= pick;
                        burst    <= '0;
                        state    <= SERVE;
                        BUSY     <= 1'b1;
                    end
                end
                SERVE: begin
                    if (pop) begin
                        burst <= burst + 8'd1;
                        if (burst + 8'd1 == BMAX) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else if (!SRC_EN[GRANT_ID] || SRC_EMPTY[GRANT_ID]) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge BUS_CLK) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (BUS_RST || CNT_CLR)
                cnt[i] <= '0;
            else if (SRC_READ[i] && cnt[i] != '1)
                cnt[i] <= cnt[i] + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < N_SRC; i++) begin : g_cnt
        assign WORD_CNT[i*CNT_W +: CNT_W] = cnt[i];
    end

endmodule

// File: tb/tb_fifo_wrr_arbiter.sv
// Bench for fifo_wrr_arbiter: queue-backed source FIFOs, a cycle reference model,
// a directed vector table and directed corner sequences, then randomized traffic.
module tb_fifo_wrr_arbiter;

    localparam int NS   = 3;
    localparam int DW   = 32;
    localparam int BMAX = 16;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] src_en;
    logic [NS-1:0] src_empty;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0] src_read;
    logic          out_full;
    logic          out_write;
    logic [DW-1:0] out_data;
    logic [1:0]    grant_id;
    logic          busy;
    logic          cnt_clr;
    logic [NS*CW-1:0] word_cnt;

    fifo_wrr_arbiter #(
        .N_SRC(NS), .DATA_W(DW), .BURST_MAX(BMAX), .CNT_W(CW)
    ) dut (
        .BUS_CLK(clk), .BUS_RST(rst), .SRC_EN(src_en),
        .SRC_EMPTY(src_empty), .SRC_DATA(src_data), .SRC_READ(src_read),
        .OUT_FULL(out_full), .OUT_WRITE(out_write), .OUT_DATA(out_data),
        .GRANT_ID(grant_id), .BUSY(busy), .CNT_CLR(cnt_clr),
        .WORD_CNT(word_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] q [NS][$];

    // Reference model state
    bit          m_serve;
    int          m_g, m_ptr, m_burst;
    bit          m_wr;
    logic [31:0] m_data;
    int          m_cnt [NS];

    int n_chk = 0;
    int n_fail = 0;
    logic [NS-1:0] last_read;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic [NS-1:0] en, input logic full,
                        input logic r, input logic clr);
        logic [NS-1:0] exp_read;
        logic [NS*CW-1:0] exp_cnt;
        int pop_src;
        bit found;
        @(negedge clk);
        src_en = en; out_full = full; rst = r; cnt_clr = clr;
        for (int i = 0; i < NS; i++) begin
            src_empty[i] = (q[i].size() == 0);
            src_data[i*DW +: DW] = (q[i].size() == 0) ? 32'h0 : q[i][0];
        end
        #1;
        exp_read = '0;
        pop_src = -1;
        if (r) begin
            m_serve = 0; m_g = 0; m_ptr = NS - 1; m_burst = 0;
            m_wr = 0; m_data = 0;
        end else if (!m_serve) begin
            m_wr = 0;
            found = 0;
            for (int k = 1; k <= NS; k++) begin
                int s;
                s = (m_ptr + k) % NS;
                if (!found && en[s] && q[s].size() > 0) begin
                    found = 1; m_g = s; m_ptr = s; m_burst = 0; m_serve = 1;
                end
            end
        end else begin
            m_wr = 0;
            if (!en[m_g] || q[m_g].size() == 0) begin
                m_serve = 0;
            end else if (!full) begin
                pop_src = m_g;
                exp_read[m_g] = 1'b1;
                m_wr = 1; m_data = q[m_g][0];
                m_burst++;
                if (m_burst == BMAX) m_serve = 0;
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (r || clr) m_cnt[i] = 0;
            else if (pop_src == i && m_cnt[i] < CMAX) m_cnt[i]++;
        end
        last_read = src_read;
        chk("src_read", 64'(src_read), 64'(exp_read));
        for (int i = 0; i < NS; i++)
            if (src_read[i] && q[i].size() > 0) void'(q[i].pop_front());
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NS; i++) exp_cnt[i*CW +: CW] = CW'(m_cnt[i]);
        chk("out_write", 64'(out_write), 64'(m_wr));
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("grant_id", 64'(grant_id), 64'(m_g));
        chk("busy", 64'(busy), 64'(m_serve));
        chk("word_cnt", 64'(word_cnt), 64'(exp_cnt));
    endtask

    task automatic flush();
        for (int i = 0; i < NS; i++) q[i].delete();
        step(3'b111, 1'b0, 1'b1, 1'b0);
    endtask

    typedef struct {
        logic [2:0] en;
        logic       full;
        logic       r;
        logic [2:0] rd;
        logic       wr;
        logic       bsy;
        logic [1:0] gid;
    } vec_t;

    vec_t tbl [9];
    logic [31:0] wlog [$];
    int          wcyc [$];
    int          nw, sz;
    logic [31:0] ew;

    initial begin
        tbl[0] = '{3'b111, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0};
        tbl[1] = '{3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 2'd1};
        for (int i = 2; i <= 6; i++)
            tbl[i] = '{3'b111, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 2'd1};
        tbl[7] = '{3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1};
        tbl[8] = '{3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1};

        rst = 1; src_en = 0; src_empty = '1; src_data = 0;
        out_full = 0; cnt_clr = 0;
        m_serve = 0; m_g = 0; m_ptr = NS - 1; m_burst = 0; m_wr = 0; m_data = 0;
        for (int i = 0; i < NS; i++) m_cnt[i] = 0;

        // Three full sources, 40 words each
        flush();
        for (int s = 0; s < NS; s++)
            for (int j = 0; j < 40; j++) q[s].push_back((s << 24) | j);
        for (int c = 0; c < 140; c++) begin
            step(3'b111, 1'b0, 1'b0, 1'b0);
            if (out_write) begin
                wlog.push_back(out_data);
                wcyc.push_back(c);
            end
        end
        chk("t1_total", 64'(wlog.size()), 64'd120);
        nw = 0;
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < NS; s++) begin
                int n;
                n = (40 - 16 * r) < 16 ? (40 - 16 * r) : 16;
                for (int j = 0; j < n; j++) begin
                    ew = (s << 24) | (16 * r + j);
                    if (nw < wlog.size()) chk("t1_order", 64'(wlog[nw]), 64'(ew));
                    nw++;
                end
            end
        if (wcyc.size() >= 96) begin
            chk("t1_span96", 64'(wcyc[95] - wcyc[0]), 64'd100);
            chk("t1_bubble", 64'(wcyc[16] - wcyc[15]), 64'd2);
        end

        // Single source, vector table
        for (int i = 0; i < NS; i++) q[i].delete();
        for (int j = 0; j < 5; j++) q[1].push_back(32'h1100_0000 | j);
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].en, tbl[i].full, tbl[i].r, 1'b0);
            chk("t2_read", 64'(last_read), 64'(tbl[i].rd));
            chk("t2_write", 64'(out_write), 64'(tbl[i].wr));
            chk("t2_busy", 64'(busy), 64'(tbl[i].bsy));
            chk("t2_gid", 64'(grant_id), 64'(tbl[i].gid));
        end
        chk("t2_cnt", 64'(word_cnt), 64'({4'd0, 4'd5, 4'd0}));

        // Backpressure mid-burst
        flush();
        for (int j = 0; j < 20; j++) q[0].push_back(32'h3000_0000 | j);
        step(3'b111, 1'b0, 1'b0, 1'b0);
        nw = 0;
        for (int c = 0; c < 5; c++) begin
            step(3'b111, 1'b0, 1'b0, 1'b0);
            nw += int'(out_write);
        end
        for (int c = 0; c < 3; c++) begin
            step(3'b111, 1'b1, 1'b0, 1'b0);
            chk("t3_noread", 64'(last_read), 64'd0);
            chk("t3_gid", 64'(grant_id), 64'd0);
            chk("t3_nowrite", 64'(out_write), 64'd0);
        end
        for (int c = 0; c < 40; c++) begin
            step(3'b111, 1'b0, 1'b0, 1'b0);
            nw += int'(out_write);
            if (!busy) break;
        end
        chk("t3_burst", 64'(nw), 64'd16);

        // Reset on a pop cycle
        flush();
        for (int j = 0; j < 10; j++) q[0].push_back(32'h4000_0000 | j);
        for (int j = 0; j < 5; j++) q[1].push_back(32'h4100_0000 | j);
        step(3'b111, 1'b0, 1'b0, 1'b0);
        step(3'b111, 1'b0, 1'b0, 1'b0);
        step(3'b111, 1'b0, 1'b0, 1'b0);
        sz = q[0].size();
        step(3'b111, 1'b0, 1'b1, 1'b0);
        chk("t4_noread", 64'(last_read), 64'd0);
        chk("t4_occ", 64'(q[0].size()), 64'(sz));
        chk("t4_nowrite", 64'(out_write), 64'd0);
        step(3'b111, 1'b0, 1'b0, 1'b0);
        chk("t4_gid", 64'(grant_id), 64'd0);
        chk("t4_busy", 64'(busy), 64'd1);

        // Counter saturation and clear-with-pop
        flush();
        for (int j = 0; j < 20; j++) q[2].push_back(32'h5200_0000 | j);
        for (int c = 0; c < 30; c++) step(3'b111, 1'b0, 1'b0, 1'b0);
        chk("t5_sat", 64'(word_cnt[8 +: 4]), 64'd15);
        q[2].push_back(32'h5200_0100);
        q[2].push_back(32'h5200_0101);
        step(3'b111, 1'b0, 1'b0, 1'b0);
        step(3'b111, 1'b0, 1'b0, 1'b1);
        chk("t5_clrpop", 64'(last_read), 64'b100);
        chk("t5_clr", 64'(word_cnt[8 +: 4]), 64'd0);
        step(3'b111, 1'b0, 1'b0, 1'b0);
        chk("t5_inc", 64'(word_cnt[8 +: 4]), 64'd1);

        // Enable dropped while served
        flush();
        for (int j = 0; j < 10; j++) q[0].push_back(32'h6000_0000 | j);
        for (int j = 0; j < 10; j++) q[1].push_back(32'h6100_0000 | j);
        for (int c = 0; c < 4; c++) step(3'b111, 1'b0, 1'b0, 1'b0);
        step(3'b110, 1'b0, 1'b0, 1'b0);
        chk("t6_noread", 64'(last_read), 64'd0);
        chk("t6_release", 64'(busy), 64'd0);
        step(3'b110, 1'b0, 1'b0, 1'b0);
        chk("t6_gid", 64'(grant_id), 64'd1);
        chk("t6_busy", 64'(busy), 64'd1);
        step(3'b110, 1'b0, 1'b0, 1'b0);
        chk("t6_read1", 64'(last_read), 64'b010);

        // Randomized traffic against the model
        flush();
        for (int c = 0; c < 3000; c++) begin
            int s;
            logic [2:0] en;
            s = $urandom_range(NS - 1);
            if ($urandom_range(99) < 45 && q[s].size() < 24)
                q[s].push_back($urandom);
            en = ($urandom_range(99) < 10) ? 3'($urandom) : 3'b111;
            step(en, $urandom_range(99) < 20, $urandom_range(999) < 5,
                 $urandom_range(99) < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
